// File: rtl/spart_pkg.sv
// Shared definitions for the SPART echo driver: bus register map, FSM states
// and the baud divisor table for a 50 MHz system clock.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CFG_LO,
    ST_CFG_HI,
    ST_IDLE,
    ST_RD_RX,
    ST_WAIT_TX,
    ST_WR_TX
  } state_e;

  // 4800, 9600, 19200, 38400 baud at 50 MHz
  function automatic logic [15:0] div_lookup(input logic [1:0] sel);
    logic [15:0] div;
    case (sel)
      2'b00:   div = 16'h028B;
      2'b01:   div = 16'h0145;
      2'b10:   div = 16'h00A2;
      default: div = 16'h0050;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_driver.sv
// Processor side of the SPART bus: programs the baud divisor, then echoes each
// received byte (XOR XFORM); 3 cycles from rx_q_empty falling to the write, stalls on tx_q_full.
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [7:0] XFORM = 8'h00,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       br_cfg,
  output logic             iocs_n,
  output logic             iorw_n,
  output logic [1:0]       ioaddr,
  inout  wire  [7:0]       databus,
  input  logic             tx_q_full,
  input  logic             rx_q_empty,
  output logic [CNT_W-1:0] echo_cnt,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [1:0]       cfg_q, cfg_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      div;
  logic [7:0]       dout;
  logic             drv_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      byte_q  <= 8'h00;
      cfg_q   <= 2'b00;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      cfg_q   <= cfg_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // sel_q freezes the baud choice for the whole CFG_LO/CFG_HI pair, so the
  // bus outputs never depend combinationally on br_cfg.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    cfg_d   = cfg_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    iocs_n  = 1'b1;
    iorw_n  = 1'b1;
    ioaddr  = ADDR_BUF;
    div     = div_lookup(sel_q);
    dout    = byte_q ^ XFORM;
    case (state_q)
      ST_INIT: begin
        sel_d   = br_cfg;
        state_d = ST_CFG_LO;
      end
      ST_CFG_LO: begin
        iocs_n  = 1'b0;
        iorw_n  = 1'b0;
        ioaddr  = ADDR_DB_LO;
        dout    = div[7:0];
        state_d = ST_CFG_HI;
      end
      ST_CFG_HI: begin
        iocs_n  = 1'b0;
        iorw_n  = 1'b0;
        ioaddr  = ADDR_DB_HI;
        dout    = div[15:8];
        cfg_d   = sel_q;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (br_cfg != cfg_q) begin
          sel_d   = br_cfg;
          state_d = ST_CFG_LO;
        end else if (!rx_q_empty) begin
          state_d = ST_RD_RX;
        end
      end
      ST_RD_RX: begin
        iocs_n  = 1'b0;
        byte_d  = databus;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (!tx_q_full) state_d = ST_WR_TX;
      end
      ST_WR_TX: begin
        iocs_n  = 1'b0;
        iorw_n  = 1'b0;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign drv_en   = ~iocs_n & ~iorw_n;
  assign databus  = drv_en ? dout : 8'hzz;
  assign echo_cnt = cnt_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver with a behavioural SPART (RX queue in, TX log out).
module tb_spart_driver;

  localparam logic [7:0] XF = 8'h3C;
  localparam int         CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    br_cfg = 2'b01;
  logic          tx_q_full = 1'b0;
  logic          rx_q_empty = 1'b1;
  logic [7:0]    rx_dat = 8'h00;
  wire           iocs_n, iorw_n, busy;
  wire [1:0]     ioaddr;
  wire [7:0]     databus;
  wire [CW-1:0]  echo_cnt;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    rxq[$];
  logic [7:0]    txlog[$];
  bit            pop_pending = 1'b0;

  always #5 clk = ~clk;

  // SPART side drives the bus only during a read cycle
  assign databus = (!iocs_n && iorw_n) ? rx_dat : 8'hzz;

  spart_driver #(.XFORM(XF), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg),
    .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr), .databus(databus),
    .tx_q_full(tx_q_full), .rx_q_empty(rx_q_empty),
    .echo_cnt(echo_cnt), .busy(busy)
  );

  // Bus monitor at negedge, SPART queue update just after posedge.
  always begin
    @(negedge clk);
    checks++;
    if (!iocs_n && ioaddr == 2'b01) begin
      errors++;
      $display("FAIL status_access: ioaddr=%b with iocs_n=0, required never 01", ioaddr);
    end else if (!iocs_n && iorw_n) begin
      if (databus !== rx_dat) begin
        errors++;
        $display("FAIL bus_read_contention: databus=%h required %h", databus, rx_dat);
      end
      if (ioaddr == 2'b00) pop_pending = 1'b1;
    end else if (iocs_n) begin
      if (iorw_n !== 1'b1 || (databus !== 8'hzz && databus !== 8'h00)) begin
        errors++;
        $display("FAIL bus_idle_drive: iorw_n=%b databus=%h required iorw_n=1 and released", iorw_n, databus);
      end
    end else if (ioaddr == 2'b00) begin
      txlog.push_back(databus);
    end
    @(posedge clk);
    #1;
    if (pop_pending) begin
      if (rxq.size() > 0) void'(rxq.pop_front());
      pop_pending = 1'b0;
    end
    rx_q_empty = (rxq.size() == 0);
    rx_dat     = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = (!iocs_n && iorw_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    br_cfg = 2'b01;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11001) begin
      errors++; $display("FAIL reset_bus: {cs,rw,addr,busy}=%b required 11001", {iocs_n, iorw_n, ioaddr, busy});
    end
    checks++;
    if (echo_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: echo_cnt=%0d required 0", echo_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b00101 || databus !== 8'h45) begin
      errors++; $display("FAIL cfg_lo_9600: {cs,rw,addr,busy}=%b data=%h required 00101 45", {iocs_n, iorw_n, ioaddr, busy}, databus);
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b00111 || databus !== 8'h01) begin
      errors++; $display("FAIL cfg_hi_9600: {cs,rw,addr,busy}=%b data=%h required 00111 01", {iocs_n, iorw_n, ioaddr, busy}, databus);
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11000) begin
      errors++; $display("FAIL cfg_idle: {cs,rw,addr,busy}=%b required 11000", {iocs_n, iorw_n, ioaddr, busy});
    end
  endtask

  task automatic test_loopback();
    logic [7:0] host [8];
    logic [7:0] expv [8];
    host = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'h7E};
    expv = '{8'h3C, 8'hC3, 8'h00, 8'h99, 8'h66, 8'h3D, 8'hBC, 8'h42};
    txlog.delete();
    for (int i = 0; i < 8; i++) rxq.push_back(host[i]);
    for (int i = 0; i < 200 && txlog.size() < 8; i++) tick();
    repeat (2) tick();
    checks++;
    if (txlog.size() != 8) begin
      errors++; $display("FAIL loop_count: tx bytes=%0d required 8", txlog.size());
    end
    for (int i = 0; i < 8 && i < txlog.size(); i++) begin
      checks++;
      if (txlog[i] !== expv[i]) begin
        errors++; $display("FAIL loop_data[%0d]: tx=%h required %h", i, txlog[i], expv[i]);
      end
    end
    checks++;
    if (echo_cnt !== 4'd8 || busy !== 1'b0) begin
      errors++; $display("FAIL loop_cnt: echo_cnt=%0d busy=%b required 8 0", echo_cnt, busy);
    end
  endtask

  task automatic test_latency();
    rxq.push_back(8'hA7);
    tick();
    checks++;
    if (rx_q_empty !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL lat_setup: rx_q_empty=%b busy=%b required 0 0", rx_q_empty, busy);
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b01001) begin
      errors++; $display("FAIL lat_rd_rx: {cs,rw,addr,busy}=%b required 01001", {iocs_n, iorw_n, ioaddr, busy});
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11001) begin
      errors++; $display("FAIL lat_wait_tx: {cs,rw,addr,busy}=%b required 11001", {iocs_n, iorw_n, ioaddr, busy});
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b00001 || databus !== 8'h9B) begin
      errors++; $display("FAIL lat_wr_tx: {cs,rw,addr,busy}=%b data=%h required 00001 9b", {iocs_n, iorw_n, ioaddr, busy}, databus);
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11000 || echo_cnt !== 4'd9) begin
      errors++; $display("FAIL lat_done: {cs,rw,addr,busy}=%b cnt=%0d required 11000 9", {iocs_n, iorw_n, ioaddr, busy}, echo_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stuck;
    stuck = 0;
    txlog.delete();
    tx_q_full = 1'b1;
    rxq.push_back(8'h11);
    wait_read(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_read_timeout: read seen=%0d required 1", ok);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11001) stuck++;
    end
    checks++;
    if (stuck != 0) begin
      errors++; $display("FAIL bp_hold: non-WAIT_TX cycles=%0d required 0", stuck);
    end
    tx_q_full = 1'b0;
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b00001 || databus !== 8'h2D) begin
      errors++; $display("FAIL bp_wr_tx: {cs,rw,addr,busy}=%b data=%h required 00001 2d", {iocs_n, iorw_n, ioaddr, busy}, databus);
    end
    tick();
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11000 || txlog.size() != 1 || echo_cnt !== 4'd10) begin
      errors++; $display("FAIL bp_single: {cs,rw,addr,busy}=%b writes=%0d cnt=%0d required 11000 1 10", {iocs_n, iorw_n, ioaddr, busy}, txlog.size(), echo_cnt);
    end
  endtask

  task automatic test_reconfig();
    bit ok;
    tx_q_full = 1'b1;
    rxq.push_back(8'h77);
    wait_read(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rc_read_timeout: read seen=%0d required 1", ok);
    end
    tick();
    br_cfg = 2'b11;
    tick();
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11001) begin
      errors++; $display("FAIL rc_hold: {cs,rw,addr,busy}=%b required 11001", {iocs_n, iorw_n, ioaddr, busy});
    end
    tx_q_full = 1'b0;
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b00001 || databus !== 8'h4B) begin
      errors++; $display("FAIL rc_echo_first: {cs,rw,addr,busy}=%b data=%h required 00001 4b", {iocs_n, iorw_n, ioaddr, busy}, databus);
    end
    tick();
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b00101 || databus !== 8'h50) begin
      errors++; $display("FAIL rc_cfg_lo: {cs,rw,addr,busy}=%b data=%h required 00101 50", {iocs_n, iorw_n, ioaddr, busy}, databus);
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b00111 || databus !== 8'h00) begin
      errors++; $display("FAIL rc_cfg_hi: {cs,rw,addr,busy}=%b data=%h required 00111 00", {iocs_n, iorw_n, ioaddr, busy}, databus);
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11000 || echo_cnt !== 4'd11) begin
      errors++; $display("FAIL rc_idle: {cs,rw,addr,busy}=%b cnt=%0d required 11000 11", {iocs_n, iorw_n, ioaddr, busy}, echo_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    txlog.delete();
    rxq.push_back(8'h99);
    wait_read(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rm_read_timeout: read seen=%0d required 1", ok);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11001 || echo_cnt !== 4'd0) begin
      errors++; $display("FAIL rm_abort: {cs,rw,addr,busy}=%b cnt=%0d required 11001 0", {iocs_n, iorw_n, ioaddr, busy}, echo_cnt);
    end
    checks++;
    if (databus !== 8'hzz && databus !== 8'h00) begin
      errors++; $display("FAIL rm_release: databus=%h required released", databus);
    end
    rxq.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b00101 || databus !== 8'h50) begin
      errors++; $display("FAIL rm_cfg_lo: {cs,rw,addr,busy}=%b data=%h required 00101 50", {iocs_n, iorw_n, ioaddr, busy}, databus);
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b00111 || databus !== 8'h00) begin
      errors++; $display("FAIL rm_cfg_hi: {cs,rw,addr,busy}=%b data=%h required 00111 00", {iocs_n, iorw_n, ioaddr, busy}, databus);
    end
    tick();
    checks++;
    if ({iocs_n, iorw_n, ioaddr, busy} !== 5'b11000 || txlog.size() != 0) begin
      errors++; $display("FAIL rm_idle: {cs,rw,addr,busy}=%b writes=%0d required 11000 0", {iocs_n, iorw_n, ioaddr, busy}, txlog.size());
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    txlog.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 13);
      rxq.push_back(b);
    end
    for (int i = 0; i < 600 && txlog.size() < 17; i++) tick();
    repeat (2) tick();
    checks++;
    if (txlog.size() != 17 || echo_cnt !== 4'd1) begin
      errors++; $display("FAIL wrap: writes=%0d cnt=%0d required 17 1", txlog.size(), echo_cnt);
    end
    for (int i = 0; i < 17 && i < txlog.size(); i++) begin
      b = 8'(i * 13) ^ XF;
      checks++;
      if (txlog[i] !== b) begin
        errors++; $display("FAIL wrap_data[%0d]: tx=%h required %h", i, txlog[i], b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_latency();
    test_backpressure();
    test_reconfig();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
